// File: rtl/wasm_bulk_mem_engine.sv
// WebAssembly bulk-memory engine: executes memory.fill / memory.copy as byte-wide bus
// transactions after an up-front 33-bit bounds check. Overlapping copies pick their direction.
package wasm_bulk_mem_pkg;
  localparam int unsigned PAGE_SIZE    = 65536;
  localparam int unsigned MEMORY_PAGES = 65536;

  typedef enum logic [1:0] {
    MEM_SIZE_1 = 2'd0,
    MEM_SIZE_2 = 2'd1,
    MEM_SIZE_4 = 2'd2,
    MEM_SIZE_8 = 2'd3
  } mem_size_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    mem_size_t   size;
    logic [63:0] wdata;
  } mem_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] rdata;
    logic        rvalid;
    logic        error;
  } mem_bus_resp_t;

  typedef enum logic [3:0] {
    MEM_OP_NONE     = 4'd0,
    MEM_LOAD_I8_U   = 4'd1,
    MEM_LOAD_I8_S   = 4'd2,
    MEM_LOAD_I32    = 4'd3,
    MEM_LOAD_I64    = 4'd4,
    MEM_STORE_I32_8 = 4'd5,
    MEM_STORE_I32   = 4'd6,
    MEM_STORE_I64   = 4'd7
  } mem_op_t;

  typedef enum logic [3:0] {
    TRAP_NONE          = 4'd0,
    TRAP_UNREACHABLE   = 4'd1,
    TRAP_OUT_OF_BOUNDS = 4'd2,
    TRAP_DIV_ZERO      = 4'd3,
    TRAP_INT_OVERFLOW  = 4'd4
  } trap_t;
endpackage

module wasm_bulk_mem_engine
  import wasm_bulk_mem_pkg::*;
#(
  parameter int unsigned MAX_PAGES = MEMORY_PAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_op_i,
  input  logic [31:0]   cmd_dst_i,
  input  logic [31:0]   cmd_src_i,
  input  logic [31:0]   cmd_len_i,
  input  logic [7:0]    cmd_val_i,
  input  logic [31:0]   cur_pages_i,
  output mem_bus_req_t  mem_req_o,
  input  mem_bus_resp_t mem_resp_i,
  output mem_op_t       mem_op_o,
  output logic          busy_o,
  output logic          done_o,
  output trap_t         trap_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_FILL_WR = 3'd2,
    S_COPY_RD = 3'd3,
    S_COPY_WR = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_op;
  logic        r_back;
  logic [31:0] r_dst;
  logic [31:0] r_src;
  logic [31:0] r_len;
  logic [31:0] r_dptr;
  logic [31:0] r_sptr;
  logic [31:0] r_rem;
  logic [7:0]  r_val;
  logic [7:0]  r_byte;
  trap_t       r_trap;

  logic [31:0] w_pages;
  logic [32:0] w_mem_size;
  logic [32:0] w_dst_end;
  logic [32:0] w_src_end;
  logic        w_oob;
  logic        w_access;
  logic        w_err;
  logic        w_last;
  logic        w_unused;

  // Bounds are evaluated only while in CHECK, so later changes of cur_pages_i are harmless.
  assign w_pages    = (cur_pages_i > 32'(MAX_PAGES)) ? 32'(MAX_PAGES) : cur_pages_i;
  assign w_mem_size = 33'(w_pages) * 33'(PAGE_SIZE);
  assign w_dst_end  = {1'b0, r_dst} + {1'b0, r_len};
  assign w_src_end  = {1'b0, r_src} + {1'b0, r_len};
  assign w_oob      = (w_dst_end > w_mem_size) || (r_op && (w_src_end > w_mem_size));
  assign w_access   = (r_state == S_FILL_WR) || (r_state == S_COPY_RD) || (r_state == S_COPY_WR);
  assign w_err      = w_access && mem_resp_i.error;
  assign w_last     = (r_rem == 32'd1);
  assign w_unused   = ^mem_resp_i.rdata[63:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cmd_valid_i) w_next = S_CHECK;
      S_CHECK: begin
        if (w_oob || (r_len == 32'd0)) w_next = S_FINISH;
        else if (r_op)                 w_next = S_COPY_RD;
        else                           w_next = S_FILL_WR;
      end
      S_FILL_WR: begin
        if (w_err)                            w_next = S_FINISH;
        else if (mem_resp_i.ready && w_last)  w_next = S_FINISH;
      end
      S_COPY_RD: begin
        if (w_err)                  w_next = S_FINISH;
        else if (mem_resp_i.rvalid) w_next = S_COPY_WR;
      end
      S_COPY_WR: begin
        if (w_err)                 w_next = S_FINISH;
        else if (mem_resp_i.ready) w_next = w_last ? S_FINISH : S_COPY_RD;
      end
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = '0;
    mem_op_o    = MEM_OP_NONE;
    cmd_ready_o = 1'b0;
    busy_o      = (r_state != S_IDLE);
    done_o      = 1'b0;
    trap_o      = TRAP_NONE;
    case (r_state)
      S_IDLE: cmd_ready_o = 1'b1;
      S_FILL_WR: begin
        mem_req_o.valid = 1'b1;
        mem_req_o.write = 1'b1;
        mem_req_o.size  = MEM_SIZE_1;
        mem_req_o.addr  = r_dptr;
        mem_req_o.wdata = {56'b0, r_val};
        mem_op_o        = MEM_STORE_I32_8;
      end
      S_COPY_RD: begin
        mem_req_o.valid = 1'b1;
        mem_req_o.size  = MEM_SIZE_1;
        mem_req_o.addr  = r_sptr;
        mem_op_o        = MEM_LOAD_I8_U;
      end
      S_COPY_WR: begin
        mem_req_o.valid = 1'b1;
        mem_req_o.write = 1'b1;
        mem_req_o.size  = MEM_SIZE_1;
        mem_req_o.addr  = r_dptr;
        mem_req_o.wdata = {56'b0, r_byte};
        mem_op_o        = MEM_STORE_I32_8;
      end
      S_FINISH: begin
        done_o = 1'b1;
        trap_o = r_trap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= 1'b0;
      r_back <= 1'b0;
      r_dst  <= '0;
      r_src  <= '0;
      r_len  <= '0;
      r_dptr <= '0;
      r_sptr <= '0;
      r_rem  <= '0;
      r_val  <= '0;
      r_byte <= '0;
      r_trap <= TRAP_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_op   <= cmd_op_i;
            r_dst  <= cmd_dst_i;
            r_src  <= cmd_src_i;
            r_len  <= cmd_len_i;
            r_val  <= cmd_val_i;
            r_trap <= TRAP_NONE;
          end
        end
        S_CHECK: begin
          if (w_oob) r_trap <= TRAP_OUT_OF_BOUNDS;
          r_rem <= r_len;
          // A copy whose destination lies above its source runs top-down so no source byte is clobbered early.
          if (r_op && (r_dst > r_src)) begin
            r_back <= 1'b1;
            r_dptr <= r_dst + r_len - 32'd1;
            r_sptr <= r_src + r_len - 32'd1;
          end else begin
            r_back <= 1'b0;
            r_dptr <= r_dst;
            r_sptr <= r_src;
          end
        end
        S_FILL_WR: begin
          if (w_err) begin
            r_trap <= TRAP_OUT_OF_BOUNDS;
          end else if (mem_resp_i.ready) begin
            r_dptr <= r_dptr + 32'd1;
            r_rem  <= r_rem - 32'd1;
          end
        end
        S_COPY_RD: begin
          if (w_err)                  r_trap <= TRAP_OUT_OF_BOUNDS;
          else if (mem_resp_i.rvalid) r_byte <= mem_resp_i.rdata[7:0];
        end
        S_COPY_WR: begin
          if (w_err) begin
            r_trap <= TRAP_OUT_OF_BOUNDS;
          end else if (mem_resp_i.ready) begin
            r_dptr <= r_back ? (r_dptr - 32'd1) : (r_dptr + 32'd1);
            r_sptr <= r_back ? (r_sptr - 32'd1) : (r_sptr + 32'd1);
            r_rem  <= r_rem - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wasm_bulk_mem_engine.md
# wasm_bulk_mem_engine

Bus initiator that executes WebAssembly bulk-memory instructions (`memory.fill`, `memory.copy`) against linear memory. It sits between the execute stage and the linear-memory bus, driving `mem_bus_req_t` byte transactions and consuming `mem_bus_resp_t`. It performs the spec-mandated up-front bounds check, so an out-of-bounds instruction traps with zero bytes modified. Overlapping copies are handled by choosing the copy direction.

## Interface
- `MAX_PAGES`, default `MEMORY_PAGES`: upper clamp applied to `cur_pages_i` when computing the memory size.
- Clock `clk`, reset `rst_n` (asynchronous, active-low).
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: engine idle and able to accept a command.
- `cmd_op_i` in 1: operation select, 0 = fill, 1 = copy.
- `cmd_dst_i` in 32: destination byte address.
- `cmd_src_i` in 32: source byte address; ignored for fill.
- `cmd_len_i` in 32: byte count.
- `cmd_val_i` in 8: fill byte.
- `cur_pages_i` in 32: current page count, from `mem_mgmt_resp.current_pages`.
- `mem_req_o` out `mem_bus_req_t`: bus request; fields `valid`, `write`, `addr`, `size`, `wdata`.
- `mem_resp_i` in `mem_bus_resp_t`: bus response; fields `ready`, `rdata`, `rvalid`, `error`.
- `mem_op_o` out `mem_op_t`: operation tag for the responder.
- `busy_o` out 1: a command is in progress.
- `done_o` out 1: one-cycle completion pulse.
- `trap_o` out `trap_t`: trap code, valid only while `done_o` is high.

## Operation
**States:** IDLE, CHECK, FILL_WR, COPY_RD, COPY_WR, FINISH.

**IDLE**
- `cmd_ready_o` = 1.
- On `cmd_valid_i`, latch op, dst, src, len, val, then go to CHECK.

**CHECK** (exactly 1 cycle)
- `mem_size` = min(`cur_pages_i`, `MAX_PAGES`) × `PAGE_SIZE`, computed 33 bits wide.
- `dst_end` = {1'b0,dst} + len, 33 bits.
- `src_end` = {1'b0,src} + len, 33 bits; evaluated for copy only.
- Out of bounds if `dst_end` > `mem_size`, or (copy and `src_end` > `mem_size`). This is a 33-bit compare, so a 32-bit wrap is caught.
- If out of bounds: set trap = `TRAP_OUT_OF_BOUNDS`, go to FINISH; no bus request is issued.
- Else if len == 0: go to FINISH with `TRAP_NONE`, no access. A zero-length access exactly at `mem_size` is legal.
- Fill: go to FILL_WR.
- Copy, dst ≤ src: forward. Pointers start at dst and src, step +1.
- Copy, dst > src: backward. Pointers start at dst+len−1 and src+len−1, step −1.
- Copy then goes to COPY_RD. A 32-bit remaining-bytes counter `rem` = len.

**FILL_WR**
- Request: `valid`=1, `write`=1, `size`=`MEM_SIZE_1`, `addr`=dptr, `wdata`={56'b0,val}.
- `mem_op_o` = `MEM_STORE_I32_8`.
- On handshake (`valid` && `ready`): dptr += 1 and `rem` −= 1.
- When `rem` reaches 0, go to FINISH.

**COPY_RD**
- Request: `valid`=1, `write`=0, `size`=`MEM_SIZE_1`, `addr`=sptr.
- `mem_op_o` = `MEM_LOAD_I8_U`.
- On `rvalid`, latch `rdata[7:0]` and go to COPY_WR.

**COPY_WR**
- Write the latched byte to dptr.
- On handshake, step both pointers and decrement `rem`.
- Go to FINISH if `rem` reaches 0, else back to COPY_RD.

**Bus error**
- `mem_resp_i.error` in any access state sets trap = `TRAP_OUT_OF_BOUNDS` and goes to FINISH. Bytes already written remain.

**FINISH**
- `done_o` = 1 and `trap_o` = latched trap for 1 cycle, then go to IDLE.
- `trap_o` = `TRAP_NONE` whenever `done_o` = 0.

**Other rules**
- Outside the access states, `mem_req_o` is all-zero (`valid`=0).
- `busy_o` = (state != IDLE).
- `cmd_valid_i` is ignored while busy.
- A change of `cur_pages_i` mid-command has no effect; bounds are fixed at CHECK.

## Timing
- Reset values: state IDLE, `cmd_ready_o`=1, `busy_o`=0, `done_o`=0, `trap_o`=`TRAP_NONE`, `mem_req_o` all zero, `mem_op_o`=0.
- Reset asserted mid-command aborts immediately; no further requests are issued.
- Accept at cycle T, CHECK at T+1, first bus request at T+2.
- Fill with `ready`=1: one byte per cycle, `done_o` at T+2+len.
- Copy with zero-wait responder: 2 cycles per byte, `done_o` at T+2+2·len.
- Trap or len==0: `done_o` at T+2.
- While `ready`=0 or `rvalid`=0, the request is held stable (address, data, size unchanged).
- Next command may be accepted the cycle after `done_o`.

## Test plan
- **Fill:** cur_pages=1, fill dst=0x10, len=4, val=0xA5 → 4 single-byte writes to 0x10..0x13 with wdata 0xA5; `done_o` at T+6; `trap_o`=NONE.
- **Overlapping backward copy:** memory 0x00..0x07 = 00..07, copy dst=0x02, src=0x00, len=4 → reads/writes at 0x03, 0x02, 0x01, 0x00 (src side), in descending order; final 0x02..0x05 = 00 01 02 03.
- **Forward copy:** dst=0x00, src=0x04, len=4, source bytes 0x11..0x14 → ascending order; 0x00..0x03 = 11 12 13 14.
- **Out-of-bounds fill:** cur_pages=1, fill dst=0xFFFF, len=2 → zero bus requests; `done_o` at T+2 with `TRAP_OUT_OF_BOUNDS`.
- **32-bit wrap:** copy src=0xFFFFFFFF, len=2 → trap, no writes.
- **Zero-length:** len=0, dst=0x10000, cur_pages=1 → no trap, no access.
- **Stalls and error:** `ready` low for 3 cycles during FILL_WR → request held, len=2 done at T+7. `error` injected on a COPY_RD → `TRAP_OUT_OF_BOUNDS`, engine returns to IDLE.
- **Reset mid-copy:** `rst_n` low in COPY_WR → `mem_req_o.valid`=0 immediately, `cmd_ready_o`=1 after release.
